// File: rtl/intunit_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package intunit_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhu  = 3'd2,
    OpMulhsu = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpMod    = 3'd6,
    OpModu   = 3'd7
  } intop_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StFixup = 2'd2,
    StDone  = 2'd3
  } intstate_t;

  function automatic logic is_div(intop_t op);
    return op inside {OpDiv, OpDivu, OpMod, OpModu};
  endfunction

  function automatic logic is_rem(intop_t op);
    return op inside {OpMod, OpModu};
  endfunction

  function automatic logic is_signed_a(intop_t op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpMod};
  endfunction

  function automatic logic is_signed_b(intop_t op);
    return op inside {OpMulh, OpDiv, OpMod};
  endfunction

endpackage

// File: rtl/intunit_absneg.sv
// Conditional two's-complement negate: magnitude on operand entry, sign restore on fixup.
module intunit_absneg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/exec_intunit.sv
// Iterative shift-add multiplier / restoring divider with start/done handshake.
// Optional macro INTUNIT_EARLY_EN: trivial operands finish straight from the start cycle.
module exec_intunit
  import intunit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  intstate_t          state_q;
  intop_t             op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_a_q, sign_b_q, b_zero_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   result_q;

  intop_t           op_in;
  logic             sign_a_in, sign_b_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in     = intop_t'(func_i);
  assign sign_a_in = is_signed_a(op_in) & a_i[WIDTH-1];
  assign sign_b_in = is_signed_b(op_in) & b_i[WIDTH-1];

  intunit_absneg #(.WIDTH(WIDTH)) u_abs_a (.val_i(a_i), .neg_i(sign_a_in), .res_o(a_mag));
  intunit_absneg #(.WIDTH(WIDTH)) u_abs_b (.val_i(b_i), .neg_i(sign_b_in), .res_o(b_mag));

  // One iteration: multiply adds into the high half and shifts right;
  // divide shifts left and keeps the trial subtraction if it did not borrow.
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div(op_q)) begin
      acc_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  intunit_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .res_o(prod_fix)
  );
  intunit_absneg #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .res_o(quo_fix)
  );
  intunit_absneg #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_a_q), .res_o(rem_fix)
  );

  // Divide by zero leaves remainder = |a|, so only the quotient needs forcing.
  always_comb begin
    fix_res = '0;
    unique case (op_q)
      OpMul:                     fix_res = prod_fix[WIDTH-1:0];
      OpMulh, OpMulhu, OpMulhsu: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OpDiv, OpDivu:             fix_res = b_zero_q ? '1 : quo_fix;
      OpMod, OpModu:             fix_res = rem_fix;
      default:                   fix_res = '0;
    endcase
  end

  logic             early;
  logic [WIDTH-1:0] early_res;

`ifdef INTUNIT_EARLY_EN
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (a_i == '0) begin
      early = 1'b1;
    end else if (is_div(op_in)) begin
      if (b_i == '0) begin
        early     = 1'b1;
        early_res = is_rem(op_in) ? a_i : '1;
      end else if (a_mag < b_mag) begin
        early     = 1'b1;
        early_res = is_rem(op_in) ? a_i : '0;
      end
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (abort_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q     <= op_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            b_zero_q <= (b_i == '0);
            opnd_q   <= is_div(op_in) ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
            cnt_q    <= CNT_W'(WIDTH - 1);
            if (early) begin
              result_q <= early_res;
              state_q  <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= StFixup;
        end
        StFixup: begin
          result_q <= fix_res;
          state_q  <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o  = ((state_q == StIdle) & start_i & ~abort_i) |
                    (state_q == StCalc) | (state_q == StFixup);
  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone) & ~abort_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_exec_intunit.sv
// Self-checking bench for exec_intunit: directed table, corner sequences, random vs. model.
module tb_exec_intunit;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [2:0]    func_i = '0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          stall_o, busy_o, done_o;
  logic [W-1:0]  result_o;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_res = '0;

  exec_intunit #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .func_i(func_i),
    .a_i(a_i), .b_i(b_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: straight arithmetic on 64-bit integers.
  function automatic logic [W-1:0] model(input int f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub, p, q;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      0: begin p = ua * ub; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3: begin p = sa * ub; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input int f, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef INTUNIT_EARLY_EN
    logic [W-1:0] ma, mb;
    bit sgn;
    sgn = (f == 4 || f == 6);
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (a == 0) return 1;
    if (f >= 4 && (b == 0 || ma < mb)) return 1;
    return W + 2;
`else
    return W + 2;
`endif
  endfunction

  task automatic run_op(input int f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string nm);
    int k, stall_cnt, lat;
    lat = exp_latency(f, a, b);
    @(negedge clk_i);
    start_i = 1'b1; func_i = 3'(f); a_i = a; b_i = b;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 1;
    while (!done_o && k < 100) begin
      if (stall_o) stall_cnt++;
      @(negedge clk_i);
      k++;
    end
    chk({nm, " done_seen"}, 64'(done_o), 64'(1));
    chk({nm, " latency"}, 64'(k), 64'(lat));
    chk({nm, " result"}, 64'(result_o), 64'(exp));
    chk({nm, " stall_cycles"}, 64'(stall_cnt), 64'(lat));
    chk({nm, " stall_at_done"}, 64'(stall_o), 64'(0));
    @(negedge clk_i);
    chk({nm, " done_one_cycle"}, 64'(done_o), 64'(0));
    last_res = result_o;
  endtask

  typedef struct {
    int           f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        nm;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int f, done_seen;
    logic [W-1:0] ra, rb;
    logic [W-1:0] specials[5];

    vecs[0]  = '{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3"};
    vecs[1]  = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
    vecs[2]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1"};
    vecs[3]  = '{3, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, "mulhsu_m1_2"};
    vecs[4]  = '{4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, "div_m7_2"};
    vecs[5]  = '{6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, "mod_m7_2"};
    vecs[6]  = '{5, 32'd100,        32'd7,          32'd14,        "divu_100_7"};
    vecs[7]  = '{7, 32'd100,        32'd7,          32'd2,         "modu_100_7"};
    vecs[8]  = '{5, 32'd5,          32'd0,          32'hFFFF_FFFF, "divu_by0"};
    vecs[9]  = '{7, 32'd5,          32'd0,          32'd5,         "modu_by0"};
    vecs[10] = '{4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
    vecs[11] = '{6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mod_ovf"};
    vecs[12] = '{5, 32'd3,          32'd10,         32'd0,         "divu_3_10"};
    vecs[13] = '{0, 32'd0,          32'h1234_5678, 32'd0,         "mul_0_x"};
    vecs[14] = '{4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, "div_neg_by0"};

    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;

    // Reset state
    #1;
    chk("reset stall", 64'(stall_o), 64'(0));
    chk("reset busy", 64'(busy_o), 64'(0));
    chk("reset done", 64'(done_o), 64'(0));
    chk("reset result", 64'(result_o), 64'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset busy", 64'(busy_o), 64'(0));

    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

    // abort together with start in IDLE: abort wins
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1; func_i = 3'd0; a_i = 32'd9; b_i = 32'd9;
    #1;
    chk("abort_start stall", 64'(stall_o), 64'(0));
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_start busy", 64'(busy_o), 64'(0));

    // abort mid-divide at t+10, then restart MUL at t+12
    @(negedge clk_i);
    start_i = 1'b1; func_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
    done_seen = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (k == 10) abort_i = 1'b1;
      if (k == 11) abort_i = 1'b0;
      if (done_o) done_seen++;
    end
    chk("abort busy", 64'(busy_o), 64'(0));
    chk("abort no_done", 64'(done_seen), 64'(0));
    chk("abort result_held", 64'(result_o), 64'(last_res));
    run_op(0, 32'd3, 32'd4, 32'd12, "mul_after_abort");

    // asynchronous reset mid-operation
    @(negedge clk_i);
    start_i = 1'b1; func_i = 3'd5; a_i = 32'd77777; b_i = 32'd13;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midreset busy", 64'(busy_o), 64'(0));
    chk("midreset result", 64'(result_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
    end
    chk("midreset no_done", 64'(done_seen), 64'(0));

    // randomized ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      f  = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      run_op(f, ra, rb, model(f, ra, rb), $sformatf("rand%0d_f%0d", n, f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_intunit.md
Name: exec_intunit

Overview:
- Parametrised iterative multiply/divide unit for the execute stage.
- Replaces the fixed 4-cycle delay-counter stall with a start/done handshake.
- Supports generic WIDTH and full signed/unsigned mul-high and div/mod.
- Execute issues an op when its decoded type is integer-calc; the unit holds the pipeline via stall_o until the result is ready.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  request op; sampled only in IDLE
- abort_i  input  1  synchronous cancel (pipeline flush/exception)
- func_i  input  3  intop_t: 0 MUL, 1 MULH, 2 MULHU, 3 MULHSU, 4 DIV, 5 DIVU, 6 MOD, 7 MODU
- a_i  input  WIDTH  operand 1 (dividend / multiplicand)
- b_i  input  WIDTH  operand 2 (divisor / multiplier)
- stall_o  output  1  hold upstream pipeline
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle result-valid pulse
- result_o  output  WIDTH  result, held until next done

Behaviour:
- FSM states: IDLE, CALC, FIXUP, DONE.
  - IDLE -> CALC on start_i & !abort_i.
  - CALC -> FIXUP when counter reaches 0.
  - FIXUP -> DONE.
  - DONE -> IDLE unconditionally.
- Start cycle (IDLE & start_i):
  - Latch func_i, signs and magnitudes of a_i and b_i.
  - Signedness per func: MULH, DIV, MOD both operands signed; MULHSU a signed, b unsigned; others unsigned.
  - Counter loads WIDTH-1.
- CALC, one bit per cycle, WIDTH cycles:
  - MUL*: shift-add on magnitudes into a 2*WIDTH product register.
  - DIV*/MOD*: restoring division on magnitudes producing quotient and remainder.
- FIXUP:
  - Product negated if operand signs differ (signed operands only).
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
  - result_o is registered here: MUL low half; MULH/MULHU/MULHSU high half; DIV/DIVU quotient; MOD/MODU remainder.
- DONE: done_o=1 for exactly one cycle; result_o valid.
- Latency: start in cycle t -> done_o in cycle t+WIDTH+2.
- stall_o (combinational) = (IDLE & start_i & !abort_i) | CALC | FIXUP. It is low in DONE so the pipeline advances and captures result_o that cycle.
- start_i is ignored in CALC, FIXUP and DONE; it is not queued.
- Divide by zero:
  - Quotient = all ones (DIV and DIVU).
  - Remainder = a_i unchanged (MOD and MODU).
  - No exception raised.
- Signed overflow (DIV most-negative / -1): quotient = most-negative, remainder = 0.
- abort_i in any state:
  - Next state IDLE; no done_o pulse; result_o holds its previous value.
  - abort_i with start_i in IDLE: abort wins, stall_o stays low.
- Reset: state IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, counter=0, internal registers 0.
- Reset mid-operation: immediate return to IDLE, no done_o.

Optional Feature:
- Macro INTUNIT_EARLY_EN.
- When defined, the start cycle checks for trivial cases and goes IDLE -> DONE directly (done_o at t+1; stall_o high only in cycle t):
  - any op with a_i==0 -> result 0;
  - div/mod op with b_i==0 -> div-by-zero results above;
  - div/mod op with |a|<|b| (magnitudes per signedness) -> quotient 0, remainder a_i.
- When not defined, every op takes the full WIDTH+2 latency.
- Results are bit-identical in both builds.

Decomposition:
- intunit_pkg holds:
  - the intop_t enum (3 bits);
  - the intstate_t enum;
  - helpers is_div(op), is_signed_a(op), is_signed_b(op).
- One natural sub-module, intunit_absneg: combinational conditional magnitude/negate, parametrised by WIDTH. Instantiated for operand entry and for result fixup.

Test Plan:
All cases use WIDTH=32.
- MUL a=7, b=0xFFFFFFFD at t -> result 0xFFFFFFEB, done_o in cycle t+34 only; stall_o high t..t+33.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; MODU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; MODU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; MOD same -> 0.
- Start DIV, assert abort_i at t+10 -> busy_o=0 at t+11, no done_o pulse, result_o unchanged; new MUL 3*4 started at t+12 -> 12 at t+46.
- With INTUNIT_EARLY_EN: DIVU 3/10 -> done_o at t+1, result 0; MUL 0*x -> 0 at t+1. Without the macro the same stimulus gives done_o at t+34 with identical results.
